serial_adder: RTL and testbench
===============================

// Module: serial_adder
//
// PURPOSE
// Parametrised multi-cycle adder built around a DIGIT-bit full-adder slice.
// Adds two WIDTH-bit operands plus carry-in, LSB digit first, one digit per
// clock; start/busy/done handshake. Replaces wide combinational ripple adders
// where area matters more than latency. Feeds later ALU/MAC lab blocks.
//
// PARAMETERS
// WIDTH  8  operand/result width in bits; >= 2
// DIGIT  1  bits added per cycle; must divide WIDTH; DIGIT==WIDTH allowed
//   STEPS = WIDTH/DIGIT is derived, not a parameter.
//
// PORTS
// clk       in   1      rising-edge clock
// rst       in   1      synchronous reset, active-high
// start     in   1      request; sampled only when not busy
// a         in   WIDTH  operand A, captured on accepted start
// b         in   WIDTH  operand B, captured on accepted start
// cin       in   1      carry-in, captured on accepted start
// busy      out  1      1 while a sum is in progress
// done      out  1      one-cycle pulse: sum/cout/overflow just updated
// sum       out  WIDTH  registered result (a+b+cin) mod 2^WIDTH
// cout      out  1      unsigned carry-out of MSB
// overflow  out  1      signed overflow = carry into MSB XOR cout
//
// BEHAVIOUR
// - States: IDLE, RUN, DONE. Reset -> IDLE; busy=0, done=0, sum=0,
//   cout=0, overflow=0, internal carry/count/shift regs cleared.
// - IDLE: start=1 at edge t -> latch a, b, cin; count=0; go RUN.
//   start=0 -> stay IDLE, outputs hold.
// - RUN: busy=1. Each edge adds digit[count] of A, B with running carry,
//   stores digit into internal shift reg, updates carry, count++.
//   Busy high during cycles t+1 .. t+STEPS exactly.
// - Last RUN edge (count==STEPS-1): commit full sum, cout, overflow to
//   output regs in the same edge; go DONE. Outputs never change otherwise.
// - DONE: busy=0, done=1 for exactly one cycle (cycle t+STEPS+1).
//   start=1 in DONE is accepted as in IDLE (back-to-back, no bubble);
//   else -> IDLE. Throughput: one result per STEPS+1 cycles.
// - start while busy: ignored; a/b/cin changes while busy: ignored.
// - DIGIT==WIDTH: STEPS=1; done two edges after start (start-to-done
//   latency = STEPS+1 edges for all DIGIT).
// - overflow needs carry into bit WIDTH-1: taken inside final digit slice
//   (for DIGIT=1 it is the carry entering the last step).
// - rst mid-RUN: abort; no done pulse; outputs forced to reset values;
//   start in the rst cycle ignored.
// - count width = clog2(STEPS), min 1; no wrap beyond STEPS-1.
// - No combinational path from inputs to outputs.
//
// TESTING
// W8/D1: a=0x0F b=0x01 cin=0 start@t -> busy t+1..t+8, done@t+9,
//   sum=0x10 cout=0 ov=0.
// W8/D1: a=0xFF b=0x01 cin=0 -> sum=0x00 cout=1 ov=0;
//   a=0x7F b=0x01 -> sum=0x80 cout=0 ov=1; a=0x80 b=0x80 -> 0x00,1,1.
// W8/D4: a=0xAB b=0x55 cin=0 -> done 3 edges after start, sum=0x00 cout=1;
//   cin=1 with a=b=0x00 -> sum=0x01.
// W8/D1: start again mid-RUN with a=0x01 b=0x01 -> ignored, first result
//   delivered; start held high in DONE -> second op accepted, busy next cycle.
// W8/D1: rst at RUN step 4 -> busy=0 done=0 sum=0 next cycle, no done pulse;
//   fresh start afterwards computes correctly.
// W4/D1 and W4/D2: exhaustive 16x16x2 a,b,cin vs a+b+cin model; check
//   sum, cout, overflow and done timing for every vector.

Source files
------------

// File: rtl/serial_adder.sv
// Multi-cycle adder: one DIGIT-bit slice per clock, LSB digit first.
// start/busy/done handshake; results committed only on the final step.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [CW-1:0]    count;

    logic [DIGIT:0]   dsum;
    logic [DIGIT-1:0] dig;
    logic             c_out;
    logic             c_msb;
    logic [WIDTH-1:0] acc_next;

    always_comb begin
        dsum = {1'b0, a_q[DIGIT-1:0]}
             + {1'b0, b_q[DIGIT-1:0]}
             + {{DIGIT{1'b0}}, carry};
        dig   = dsum[DIGIT-1:0];
        c_out = dsum[DIGIT];
        // carry into the slice MSB, recovered from its sum bit
        c_msb = dig[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];
        acc_next = (acc >> DIGIT)
                 | (WIDTH'(dig) << (WIDTH - DIGIT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc      <= '0;
            carry    <= 1'b0;
            count    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        carry <= cin;
                        acc   <= '0;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_q   <= a_q >> DIGIT;
                    b_q   <= b_q >> DIGIT;
                    acc   <= acc_next;
                    carry <= c_out;
                    if (count == LAST) begin
                        sum      <= acc_next;
                        cout     <= c_out;
                        overflow <= c_msb ^ c_out;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: W8/D1, W8/D4, W4/D1, W4/D2 instances.
// Inputs driven and outputs sampled on the falling edge.
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    // W8/D1
    logic       s1 = 0, c1 = 0;
    logic [7:0] a1 = 0, b1 = 0;
    logic       busy1, done1, cout1, ov1;
    logic [7:0] sum1;
    // W8/D4
    logic       s4 = 0, c4 = 0;
    logic [7:0] a4 = 0, b4 = 0;
    logic       busy4, done4, cout4, ov4;
    logic [7:0] sum4;
    // W4/D1
    logic       sx = 0, cx = 0;
    logic [3:0] ax = 0, bx = 0;
    logic       busyx, donex, coutx, ovx;
    logic [3:0] sumx;
    // W4/D2
    logic       sy = 0, cy = 0;
    logic [3:0] ay = 0, by = 0;
    logic       busyy, doney, couty, ovy;
    logic [3:0] sumy;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
        .clk(clk), .rst(rst), .start(s1), .a(a1), .b(b1), .cin(c1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1),
        .overflow(ov1));
    serial_adder #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
        .clk(clk), .rst(rst), .start(s4), .a(a4), .b(b4), .cin(c4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4),
        .overflow(ov4));
    serial_adder #(.WIDTH(4), .DIGIT(1)) u_w4d1 (
        .clk(clk), .rst(rst), .start(sx), .a(ax), .b(bx), .cin(cx),
        .busy(busyx), .done(donex), .sum(sumx), .cout(coutx),
        .overflow(ovx));
    serial_adder #(.WIDTH(4), .DIGIT(2)) u_w4d2 (
        .clk(clk), .rst(rst), .start(sy), .a(ay), .b(by), .cin(cy),
        .busy(busyy), .done(doney), .sum(sumy), .cout(couty),
        .overflow(ovy));

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({busy1, done1, sum1, cout1, ov1} !== 11'b0) begin
            bad++;
            $display("FAIL reset_w8d1 got=%h want=0",
                     {busy1, done1, sum1, cout1, ov1});
        end
        total++;
        if ({busy4, done4, sum4, cout4, ov4} !== 11'b0) begin
            bad++;
            $display("FAIL reset_w8d4 got=%h want=0",
                     {busy4, done4, sum4, cout4, ov4});
        end
        total++;
        if ({busyx, donex, sumx, coutx, ovx, busyy, doney, sumy, couty, ovy}
            !== 16'b0) begin
            bad++;
            $display("FAIL reset_w4 got=%h want=0",
                     {busyx, donex, sumx, coutx, ovx,
                      busyy, doney, sumy, couty, ovy});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // a, b, cin, sum, cout, ov
    task automatic test_w8d1_basic();
        logic [18:0] vec [4];
        vec[0] = {8'h0F, 8'h01, 1'b0, 2'b00};
        vec[1] = {8'hFF, 8'h01, 1'b0, 2'b10};
        vec[2] = {8'h7F, 8'h01, 1'b0, 2'b01};
        vec[3] = {8'h80, 8'h80, 1'b0, 2'b11};
        for (int v = 0; v < 4; v++) begin
            logic [7:0] es;
            case (v)
                0: es = 8'h10;
                1: es = 8'h00;
                2: es = 8'h80;
                default: es = 8'h00;
            endcase
            a1 = vec[v][18:11];
            b1 = vec[v][10:3];
            c1 = vec[v][2];
            s1 = 1'b1;
            @(negedge clk);
            s1 = 1'b0;
            for (int i = 0; i < 8; i++) begin
                total++;
                if ({busy1, done1} !== 2'b10) begin
                    bad++;
                    $display("FAIL w8d1_busy v=%0d i=%0d got=%b want=10",
                             v, i, {busy1, done1});
                end
                @(negedge clk);
            end
            total++;
            if ({busy1, done1, sum1, cout1, ov1} !==
                {2'b01, es, vec[v][1:0]}) begin
                bad++;
                $display("FAIL w8d1_result v=%0d got=%h want=%h", v,
                         {busy1, done1, sum1, cout1, ov1},
                         {2'b01, es, vec[v][1:0]});
            end
            @(negedge clk);
            total++;
            if ({busy1, done1, sum1} !== {2'b00, es}) begin
                bad++;
                $display("FAIL w8d1_hold v=%0d got=%h want=%h", v,
                         {busy1, done1, sum1}, {2'b00, es});
            end
        end
    endtask

    task automatic test_w8d4();
        int n;
        a4 = 8'hAB; b4 = 8'h55; c4 = 1'b0; s4 = 1'b1;
        @(negedge clk);
        s4 = 1'b0;
        n = 1;
        while (!done4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n !== 3) begin
            bad++;
            $display("FAIL w8d4_latency got=%0d want=3", n);
        end
        total++;
        if ({sum4, cout4, ov4} !== {8'h00, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL w8d4_sum1 got=%h want=%h",
                     {sum4, cout4, ov4}, {8'h00, 2'b10});
        end
        a4 = 8'h00; b4 = 8'h00; c4 = 1'b1; s4 = 1'b1;
        @(negedge clk);
        s4 = 1'b0;
        n = 1;
        while (!done4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if ({n[3:0], sum4, cout4, ov4} !== {4'd3, 8'h01, 2'b00}) begin
            bad++;
            $display("FAIL w8d4_cin got=%h want=%h",
                     {n[3:0], sum4, cout4, ov4}, {4'd3, 8'h01, 2'b00});
        end
    endtask

    task automatic test_back_to_back();
        int n;
        a1 = 8'h0F; b1 = 8'h01; c1 = 1'b0; s1 = 1'b1;
        @(negedge clk);
        s1 = 1'b0;
        repeat (3) @(negedge clk);
        a1 = 8'h01; b1 = 8'h01; s1 = 1'b1;
        @(negedge clk);
        s1 = 1'b0; a1 = 8'h55; b1 = 8'h55;
        n = 5;
        while (!done1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        total++;
        if ({n[4:0], sum1, cout1, ov1} !== {5'd9, 8'h10, 2'b00}) begin
            bad++;
            $display("FAIL ignore_start got=%h want=%h",
                     {n[4:0], sum1, cout1, ov1}, {5'd9, 8'h10, 2'b00});
        end
        a1 = 8'h7F; b1 = 8'h01; c1 = 1'b0; s1 = 1'b1;
        @(negedge clk);
        s1 = 1'b0;
        total++;
        if ({busy1, done1} !== 2'b10) begin
            bad++;
            $display("FAIL b2b_accept got=%b want=10", {busy1, done1});
        end
        n = 1;
        while (!done1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        total++;
        if ({n[4:0], sum1, cout1, ov1} !== {5'd9, 8'h80, 2'b01}) begin
            bad++;
            $display("FAIL b2b_result got=%h want=%h",
                     {n[4:0], sum1, cout1, ov1}, {5'd9, 8'h80, 2'b01});
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int n;
        int seen;
        a1 = 8'h0F; b1 = 8'h01; c1 = 1'b0; s1 = 1'b1;
        @(negedge clk);
        s1 = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1; s1 = 1'b1;
        @(negedge clk);
        rst = 1'b0; s1 = 1'b0;
        total++;
        if ({busy1, done1, sum1, cout1, ov1} !== 11'b0) begin
            bad++;
            $display("FAIL mid_rst got=%h want=0",
                     {busy1, done1, sum1, cout1, ov1});
        end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy1 || done1) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL mid_rst_quiet got=%0d want=0", seen);
        end
        a1 = 8'h3C; b1 = 8'h4A; c1 = 1'b1; s1 = 1'b1;
        @(negedge clk);
        s1 = 1'b0;
        n = 1;
        while (!done1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        total++;
        if ({n[4:0], sum1, cout1, ov1} !== {5'd9, 8'h87, 2'b01}) begin
            bad++;
            $display("FAIL post_rst got=%h want=%h",
                     {n[4:0], sum1, cout1, ov1}, {5'd9, 8'h87, 2'b01});
        end
        @(negedge clk);
    endtask

    task automatic test_exhaustive_w4d1();
        int n;
        logic [4:0] t;
        logic ev;
        for (int i = 0; i < 512; i++) begin
            ax = i[8:5]; bx = i[4:1]; cx = i[0]; sx = 1'b1;
            t = {1'b0, ax} + {1'b0, bx} + {4'b0, cx};
            ev = (ax[3] == bx[3]) && (t[3] != ax[3]);
            @(negedge clk);
            sx = 1'b0;
            n = 1;
            while (!donex && n < 20) begin
                @(negedge clk);
                n++;
            end
            total++;
            if ({n[3:0], busyx, sumx, coutx, ovx} !==
                {4'd5, 1'b0, t[3:0], t[4], ev}) begin
                bad++;
                $display("FAIL w4d1 a=%h b=%h c=%b got=%h want=%h",
                         ax, bx, cx, {n[3:0], busyx, sumx, coutx, ovx},
                         {4'd5, 1'b0, t[3:0], t[4], ev});
            end
        end
        @(negedge clk);
    endtask

    task automatic test_exhaustive_w4d2();
        int n;
        logic [4:0] t;
        logic ev;
        for (int i = 0; i < 512; i++) begin
            ay = i[8:5]; by = i[4:1]; cy = i[0]; sy = 1'b1;
            t = {1'b0, ay} + {1'b0, by} + {4'b0, cy};
            ev = (ay[3] == by[3]) && (t[3] != ay[3]);
            @(negedge clk);
            sy = 1'b0;
            n = 1;
            while (!doney && n < 20) begin
                @(negedge clk);
                n++;
            end
            total++;
            if ({n[3:0], busyy, sumy, couty, ovy} !==
                {4'd3, 1'b0, t[3:0], t[4], ev}) begin
                bad++;
                $display("FAIL w4d2 a=%h b=%h c=%b got=%h want=%h",
                         ay, by, cy, {n[3:0], busyy, sumy, couty, ovy},
                         {4'd3, 1'b0, t[3:0], t[4], ev});
            end
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_w8d1_basic();
        test_w8d4();
        test_back_to_back();
        test_reset_mid_run();
        test_exhaustive_w4d1();
        test_exhaustive_w4d2();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
